// File: rtl/samp_iter.sv
// Sample iterator: walks a step-aligned bounding box row-major and emits SAMPS
// horizontally adjacent sample positions per batch, together with the held triangle and colour.
module samp_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     ready_R13H,
    input  logic                     stall_R14H,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
    output logic                     validSamp_R14H
);

    localparam int XW      = SIGFIG + 2;
    localparam int SAMP_SH = $clog2(SAMPS);

    typedef enum logic {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

    state_t state_q, state_d;

    logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];
    logic signed [SIGFIG-1:0] samp_q  [2][SAMPS];
    logic signed [SIGFIG-1:0] samp_d  [2][SAMPS];

    logic signed [SIGFIG-1:0] llx_q, llx_d;
    logic signed [SIGFIG-1:0] urx_q, urx_d;
    logic signed [SIGFIG-1:0] ury_q, ury_d;
    logic signed [SIGFIG-1:0] x0_q, x0_d;
    logic signed [SIGFIG-1:0] y_q, y_d;
    logic        [SIGFIG-1:0] step_q, step_d;
    logic                     single_q, single_d;
    logic                     vld_q, vld_d;

    logic        [SIGFIG-1:0] step_in;
    logic signed [XW-1:0]     x0_ext, y_ext, step_ext, urx_ext, ury_ext;
    logic signed [XW-1:0]     nx, ny;
    logic                     adv_x, adv_y, last_batch;
    logic                     accept, consume;
    logic signed [SIGFIG-1:0] acc;

    // Unrecognised sample-rate codes fall back to one sample per pixel.
    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: step_in = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_in = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_in = SIGFIG'(1) << (RADIX - 3);
            default: step_in = SIGFIG'(1) << RADIX;
        endcase
    end

    // Two guard bits keep the end-of-row/end-of-box compares honest near the top of the range.
    always_comb begin
        x0_ext     = XW'(x0_q);
        y_ext      = XW'(y_q);
        step_ext   = XW'(step_q);
        urx_ext    = XW'(urx_q);
        ury_ext    = XW'(ury_q);
        nx         = x0_ext + (step_ext <<< SAMP_SH);
        ny         = y_ext + step_ext;
        adv_x      = (nx <= urx_ext);
        adv_y      = (ny <= ury_ext);
        last_batch = single_q | (~adv_x & ~adv_y);
    end

    // FSM output logic
    always_comb begin
        ready_R13H = (state_q == ST_WAIT) & ~stall_R14H;
        accept     = validTri_R13H & ready_R13H;
        consume    = (state_q == ST_TEST) & ~stall_R14H;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (accept) state_d = ST_TEST;
            ST_TEST: if (consume && last_batch) state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        tri_d    = tri_q;
        color_d  = color_q;
        llx_d    = llx_q;
        urx_d    = urx_q;
        ury_d    = ury_q;
        x0_d     = x0_q;
        y_d      = y_q;
        step_d   = step_q;
        single_d = single_q;
        vld_d    = vld_q;
        if (accept) begin
            tri_d    = tri_R13S;
            color_d  = color_R13U;
            llx_d    = box_R13S[0][0];
            urx_d    = box_R13S[1][0];
            ury_d    = box_R13S[1][1];
            x0_d     = box_R13S[0][0];
            y_d      = box_R13S[0][1];
            step_d   = step_in;
            // An inverted box on either axis still produces its single batch at ll.
            single_d = (box_R13S[1][0] < box_R13S[0][0]) | (box_R13S[1][1] < box_R13S[0][1]);
            vld_d    = 1'b1;
        end else if (consume) begin
            if (last_batch) begin
                vld_d = 1'b0;
            end else if (adv_x) begin
                x0_d = nx[SIGFIG-1:0];
            end else begin
                x0_d = llx_q;
                y_d  = ny[SIGFIG-1:0];
            end
        end
    end

    // Sample positions follow x0/y, so they hold whenever x0/y hold.
    always_comb begin
        acc = x0_d;
        for (int i = 0; i < SAMPS; i++) begin
            samp_d[0][i] = acc;
            samp_d[1][i] = y_d;
            acc          = acc + $signed(step_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_q[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                color_q[c] <= '0;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < SAMPS; i++)
                    samp_q[d][i] <= '0;
            llx_q    <= '0;
            urx_q    <= '0;
            ury_q    <= '0;
            x0_q     <= '0;
            y_q      <= '0;
            step_q   <= '0;
            single_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            tri_q    <= tri_d;
            color_q  <= color_d;
            samp_q   <= samp_d;
            llx_q    <= llx_d;
            urx_q    <= urx_d;
            ury_q    <= ury_d;
            x0_q     <= x0_d;
            y_q      <= y_d;
            step_q   <= step_d;
            single_q <= single_d;
            vld_q    <= vld_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = samp_q;
    assign validSamp_R14H = vld_q;

endmodule

// File: doc/samp_iter.md
Name: samp_iter

Overview:
- Rasterizer stage directly upstream of the sample-test stage.
- Accepts one triangle plus its step-aligned bounding box from the bbox stage.
- Walks the box row-major and emits SAMPS horizontally adjacent sample positions per cycle, with the triangle and colour, to the sample-test stage.
- Backpressures the bbox stage while iterating and honours a stall from downstream.

Parameters:
- SIGFIG, 24: bits in colour and position.
- RADIX, 10: fraction bits in position.
- VERTS, 3: vertices per triangle.
- AXIS, 3: axes per vertex (x,y,z).
- COLORS, 3: colour channels.
- SAMPS, 4: samples emitted per cycle. Power of two, 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bbox stage.
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle colour.
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box; [0]=lower-left (x,y), [1]=upper-right (x,y), inclusive.
- validTri_R13H  in  1  triangle/box valid.
- subSample_RnnnnU  in  [3:0]  one-hot sample rate; quasi-static, changed only while idle.
- ready_R13H  out  1  iterator accepts a triangle this cycle.
- stall_R14H  in  1  downstream stall.
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  held triangle.
- color_R14U  out  [SIGFIG-1:0] [COLORS]  held colour.
- sample_R14S  out  signed [SIGFIG-1:0] [2][SAMPS]  [0]=x, [1]=y of each sample.
- validSamp_R14H  out  1  sample batch valid.

Behaviour:
- Step size from subSample_RnnnnU:
  - 1000 -> 1<<RADIX (1 spp)
  - 0100 -> 1<<(RADIX-1)
  - 0010 -> 1<<(RADIX-2)
  - 0001 -> 1<<(RADIX-3)
  - Any other code: treated as 1000.
- Box corners arrive already aligned to the step grid (the bbox stage guarantees this). The iterator does not realign.
- States: WAIT, TEST.
- ready_R13H = (state==WAIT) & !stall_R14H. Combinational from registered state and the stall input.
- Accept occurs on a clock edge where validTri_R13H & ready_R13H. On that edge:
  - tri, colour, box and step are captured.
  - Outputs load the first batch: x_i = ll.x + i*step for i=0..SAMPS-1, y = ll.y.
  - validSamp_R14H = 1, state -> TEST.
  - Latency is 1 edge from accept to first valid batch.
- In TEST, on each edge with stall_R14H=0 (compute next x and y in SIGFIG+2 bits, no wrap):
  - nx = x0 + SAMPS*step.
  - If nx <= ur.x: x0 = nx.
  - Else if y + step <= ur.y: x0 = ll.x, y = y + step.
  - Else (last batch consumed): state -> WAIT, validSamp_R14H = 0; tri/colour/sample outputs keep their last values.
- stall_R14H=1: state, all outputs and captured registers hold. No accept occurs.
- Samples with x_i > ur.x may be emitted in the last batch of a row. They lie strictly outside the triangle and downstream reports them as misses. No per-sample mask.
- One bubble cycle (validSamp=0) always separates two triangles.
- Degenerate box (ll==ur): exactly one batch, then WAIT.
- Box with ur < ll on either axis: still emits exactly one batch at ll, then WAIT.
- Reset (asserted at any time, including mid-triangle): state=WAIT, all outputs 0, captured registers 0, ready_R13H=1 once rst deasserts. The in-progress triangle is discarded.
- Outputs are fully registered except ready_R13H.

Test Plan:
1. 1 spp, SAMPS=4, box ll=(0,0) ur=(4096,2048): exactly 6 valid batches, one per cycle.
   - Batch x0 sequence: 0,4096,0,4096,0,4096.
   - Batch y sequence: 0,0,1024,1024,2048,2048.
   - First batch samples x = 0,1024,2048,3072.
   - ready_R13H=0 for those 6 cycles, then 1.
2. subSample=0100, box ll=(1024,1024) ur=(2048,1536):
   - Step 512; batches (1024,1024), (1024,1536) only.
   - Second batch samples x = 1024,1536,2048,2560.
3. Degenerate box ll=ur=(3072,5120) -> single batch (3072..6144 step 1024, y=5120), validSamp high 1 cycle.
4. Stall: in scenario 1, assert stall_R14H for 3 cycles during batch 2 -> outputs frozen at x0=4096, y=0 for 4 cycles total. Sequence otherwise unchanged. ready stays 0.
5. Reset mid-triangle: assert rst during batch 3 of scenario 1 -> validSamp=0 and all outputs 0 immediately. Next triangle accepted normally on the first edge after rst deasserts.
6. Back-to-back triangles with validTri held high -> second accepted on the edge after the first's last batch; exactly one validSamp=0 cycle between them.
